// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and sizing helpers for the instruction fetch unit.
package fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetched {pc, inst} entries with flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    fetch_entry_t mem [DEPTH];
    logic [PW-1:0] rd, wr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign dout  = mem[rd];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= nxt(wr);
            if (pop) rd <= nxt(rd);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited instruction fetch with in-order responses,
// redirect flush and stale-response kill counting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        valid,
    output logic        clr
);
    localparam int CW = cnt_w(BUF_DEPTH);
    localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

    logic [31:0] fetch_pc, resp_pc, tgt;
    logic [CW-1:0] outst, kill, count;
    logic [CW:0] occ;
    logic grant, push, pop, empty, full;
    fetch_entry_t head;

    assign tgt       = {redirect_pc[31:2], 2'b00};
    assign valid     = ~empty;
    assign pop       = valid & ~stop & ~redirect;
    assign push      = imem_rvalid & (kill == '0) & ~redirect & (~full | pop);
    // Counting this cycle's pop as free credit lets zero-wait memory stream without bubbles.
    assign occ       = {1'b0, outst} + {1'b0, count} - (CW+1)'(pop);
    assign imem_req  = ~rst & ~redirect & (occ < (CW+1)'(BUF_DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req & imem_gnt;
    assign clr       = rst | redirect;
    assign inst      = valid ? head.inst : '0;
    assign pc        = valid ? head.pc : '0;

    fetch_fifo #(.DEPTH(BUF_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .din   ('{pc: resp_pc, inst: imem_rdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= BOOT_PC;
            resp_pc  <= BOOT_PC;
            outst    <= '0;
            kill     <= '0;
        end else if (redirect) begin
            fetch_pc <= tgt;
            resp_pc  <= tgt;
            outst    <= outst - CW'(imem_rvalid);
            kill     <= outst - CW'(imem_rvalid);
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (push) resp_pc <= resp_pc + 32'd4;
            if (imem_rvalid && kill != '0) kill <= kill - 1'b1;
            outst <= outst + CW'(grant) - CW'(imem_rvalid);
        end
    end
endmodule
